// File: rtl/oric_tape_pkg.sv
// Shared types and helpers for the Oric cassette deck: state encodings,
// frame geometry, parity and the record-path gap limit.
package oric_tape_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLatch,
      StShift,
      StEnd,
      StRec
   } deck_state_e;

   typedef enum logic {
      RxHunt,
      RxBits
   } rx_state_e;

   // Start bit + 8 data bits + parity bit, stop bits come on top.
   localparam int unsigned FRAME_HEAD_BITS = 10;
   localparam int unsigned GAP_HALVES      = 4;

   function automatic int unsigned frame_bits(input int unsigned stop_bits);
      return FRAME_HEAD_BITS + stop_bits;
   endfunction

   // Longest rising-edge-to-rising-edge period still treated as part of a byte.
   function automatic int unsigned gap_limit(input int unsigned half_long);
      return GAP_HALVES * half_long;
   endfunction

   // Parity bit that makes the ones count of data + parity odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/oric_tape_rx.sv
// Record-path front end: synchronises K7_TAPEOUT, measures rising-edge periods
// and deserialises LSB-first Oric frames into bytes with a parity verdict.
module oric_tape_rx
   import oric_tape_pkg::*;
#(
   parameter int unsigned HALF_SHORT = 1250,
   parameter int unsigned HALF_LONG  = 2500,
   parameter int unsigned CW         = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       clear,
   input  logic       tape_in,
   output logic       byte_valid,
   output logic [7:0] data_byte,
   output logic       parity_err
);

   // period_q holds (edge-to-edge period - 1), so the limits are shifted by one.
   localparam logic [CW-1:0] ONE_LIMIT = CW'(HALF_SHORT + HALF_LONG - 1);
   localparam logic [CW-1:0] GAP_LIMIT = CW'(gap_limit(HALF_LONG));

   logic          sync1_q, sync2_q, prev_q;
   logic [CW-1:0] period_q;
   rx_state_e     state_q;
   logic [8:0]    shift_q;
   logic [3:0]    bit_cnt_q;
   logic          rise, gap, bit_val;
   logic [8:0]    shift_next;

   // Edges seen while paused are dropped, prev_q keeps tracking regardless.
   assign rise       = en & sync2_q & ~prev_q;
   assign gap        = (period_q >= GAP_LIMIT);
   assign bit_val    = (period_q < ONE_LIMIT);
   assign shift_next = {bit_val, shift_q[8:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         prev_q     <= 1'b0;
         period_q   <= '1;
         state_q    <= RxHunt;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         byte_valid <= 1'b0;
         data_byte  <= '0;
         parity_err <= 1'b0;
      end else begin
         sync1_q    <= tape_in;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         byte_valid <= 1'b0;
         if (clear) begin
            period_q  <= '1;
            state_q   <= RxHunt;
            bit_cnt_q <= '0;
         end else if (rise) begin
            period_q <= '0;
            if (gap) begin
               state_q   <= RxHunt;
               bit_cnt_q <= '0;
            end else begin
               unique case (state_q)
                  RxHunt: begin
                     if (!bit_val) begin
                        state_q   <= RxBits;
                        bit_cnt_q <= '0;
                     end
                  end
                  RxBits: begin
                     shift_q <= shift_next;
                     if (bit_cnt_q == 4'd8) begin
                        byte_valid <= 1'b1;
                        data_byte  <= shift_next[7:0];
                        parity_err <= ~^shift_next;
                        state_q    <= RxHunt;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
                  default: state_q <= RxHunt;
               endcase
            end
         end else if (en && (period_q != '1)) begin
            period_q <= period_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/oric_tape_deck.sv
// Oric cassette deck: plays a TAP image from byte RAM as a K7_TAPEIN waveform and,
// when built with TAPE_RECORD_EN, records K7_TAPEOUT back into the same RAM.
module oric_tape_deck
   import oric_tape_pkg::*;
#(
   parameter int unsigned AW         = 16,
   parameter int unsigned HALF_SHORT = 1250,
   parameter int unsigned HALF_LONG  = 2500,
   parameter int unsigned STOP_BITS  = 4,
   parameter int unsigned CW         = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          rewind,
   input  logic          mode_rec,
   input  logic [AW-1:0] tape_end,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_q,
   output logic          mem_we,
   output logic [7:0]    mem_d,
   input  logic          tape_in,
   output logic          data,
   output logic          playing,
   output logic          at_end,
   output logic [AW:0]   rec_len,
   output logic          rec_err
);

   localparam int unsigned   FRAME_BITS = frame_bits(STOP_BITS);
   localparam int unsigned   BW         = $clog2(FRAME_BITS);
   localparam logic [CW-1:0] SHORT_M1   = CW'(HALF_SHORT - 1);
   localparam logic [CW-1:0] LONG_M1    = CW'(HALF_LONG - 1);

   deck_state_e           state_q;
   logic [AW-1:0]         addr_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic [BW-1:0]         bit_cnt_q;
   logic [CW-1:0]         half_cnt_q;
   logic                  data_q, playing_q, at_end_q;

   function automatic logic [CW-1:0] half_len(input logic b);
      return b ? SHORT_M1 : LONG_M1;
   endfunction

`ifdef TAPE_RECORD_EN
   logic          rec_active, rx_en, rx_valid, rx_perr, rec_write;
   logic [7:0]    rx_byte;
   logic          mem_we_q, rec_err_q;
   logic [7:0]    mem_d_q;
   logic [AW:0]   rec_len_q;

   assign rec_active = (state_q == StRec);
   assign rx_en      = en & rec_active;
   assign rec_write  = rec_active & rx_valid & ~rx_perr & ~rec_len_q[AW];

   oric_tape_rx #(
      .HALF_SHORT (HALF_SHORT),
      .HALF_LONG  (HALF_LONG),
      .CW         (CW)
   ) u_rx (
      .clk        (clk),
      .reset      (reset),
      .en         (rx_en),
      .clear      (rewind),
      .tape_in    (tape_in),
      .byte_valid (rx_valid),
      .data_byte  (rx_byte),
      .parity_err (rx_perr)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_we_q  <= 1'b0;
         mem_d_q   <= '0;
         rec_len_q <= '0;
         rec_err_q <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         if (rewind) begin
            rec_err_q <= 1'b0;
         end else if (rec_write) begin
            mem_we_q  <= 1'b1;
            mem_d_q   <= rx_byte;
            rec_len_q <= rec_len_q + (AW+1)'(1);
         end else if (rec_active && rx_valid && rx_perr && !rec_len_q[AW]) begin
            rec_err_q <= 1'b1;
         end
      end
   end

   assign mem_we  = mem_we_q;
   assign mem_d   = mem_d_q;
   assign rec_len = rec_len_q;
   assign rec_err = rec_err_q;
`else
   logic unused_tape_in;
   assign unused_tape_in = tape_in;
   assign mem_we         = 1'b0;
   assign mem_d          = '0;
   assign rec_len        = '0;
   assign rec_err        = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         frame_q    <= '0;
         bit_cnt_q  <= '0;
         half_cnt_q <= '0;
         data_q     <= 1'b0;
         playing_q  <= 1'b0;
         at_end_q   <= 1'b0;
      end else if (rewind) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         data_q    <= 1'b0;
         playing_q <= 1'b0;
         at_end_q  <= 1'b0;
      end else begin
`ifdef TAPE_RECORD_EN
         // Write address is presented together with the mem_we pulse.
         if (rec_write) addr_q <= rec_len_q[AW-1:0];
         if (rec_active && rec_len_q[AW]) at_end_q <= 1'b1;
`endif
         if (en) begin
            unique case (state_q)
               StIdle: begin
                  if (!mode_rec && !at_end_q) begin
                     state_q   <= StFetch;
                     playing_q <= 1'b1;
                  end
`ifdef TAPE_RECORD_EN
                  else if (mode_rec) state_q <= StRec;
`endif
               end
               StFetch: state_q <= StLatch;
               StLatch: begin
                  frame_q    <= {{STOP_BITS{1'b1}}, odd_parity(mem_q), mem_q, 1'b0};
                  bit_cnt_q  <= BW'(FRAME_BITS - 1);
                  half_cnt_q <= LONG_M1;
                  data_q     <= 1'b1;
                  state_q    <= StShift;
               end
               StShift: begin
                  if (half_cnt_q != '0) begin
                     half_cnt_q <= half_cnt_q - CW'(1);
                  end else if (data_q) begin
                     data_q     <= 1'b0;
                     half_cnt_q <= half_len(frame_q[0]);
                  end else if (bit_cnt_q != '0) begin
                     frame_q    <= frame_q >> 1;
                     bit_cnt_q  <= bit_cnt_q - BW'(1);
                     data_q     <= 1'b1;
                     half_cnt_q <= half_len(frame_q[1]);
                  end else if (addr_q == tape_end) begin
                     state_q   <= StEnd;
                     at_end_q  <= 1'b1;
                     playing_q <= 1'b0;
                  end else begin
                     addr_q  <= addr_q + AW'(1);
                     state_q <= StFetch;
                  end
               end
               StEnd: ;
               StRec: ;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign mem_addr = addr_q;
   assign data     = data_q;
   assign playing  = playing_q;
   assign at_end   = at_end_q;

endmodule
